// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, RV32I opcodes
// and the datapath select / ALU operation codes.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JUMP, S_JALRADR, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // alt selects the sub/sra variant; callers decide when alt is meaningful
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: ALU operation for R/I-ALU instructions and
// a flag for any encoding the core does not implement.
module alu_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                alu_ctrl_o = alu_from_f3(funct3_i, funct7_i[5]);
                if (funct7_i != 7'b0000000 && funct7_i != 7'b0100000)
                    illegal_o = 1'b1;
                else if (funct7_i[5] && funct3_i != 3'b000 && funct3_i != 3'b101)
                    illegal_o = 1'b1;
            end
            // addi has no subtract form, so funct7[5] only matters for srai
            OP_IALU:   alu_ctrl_o = alu_from_f3(funct3_i, (funct3_i == 3'b101) && funct7_i[5]);
            OP_BRANCH: begin
                alu_ctrl_o = ALU_SUB;
                illegal_o  = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle RV32I control unit: sequences each instruction through a shared
// ALU and a unified memory port, driving all datapath selects and strobes.
//
// state     | meaning
// FETCH     | read instr at PC, PC <- PC+4 when memory is ready
// DECODE    | ALUOut <- oldPC+imm, dispatch on opcode
// MEMADR    | ALUOut <- rs1+imm (load/store address)
// MEMREAD   | read data at ALUOut, wait for memory
// MEMWB     | rd <- memory data
// MEMWRITE  | write rs2 to ALUOut, wait for memory
// EXECR     | rs1 op rs2
// EXECI     | rs1 op imm
// ALUWB     | rd <- ALUOut
// BRANCH    | compare rs1/rs2, PC <- ALUOut if taken
// JALRADR   | ALUOut <- rs1+imm (jalr target)
// JUMP      | PC <- ALUOut, link value oldPC+4 computed
// LUI       | ALU passes U-immediate
// AUIPC     | oldPC + U-immediate
// TRAP      | illegal instruction, parked until reset
module mc_cu
    import cu_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        illegal
);

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       mem_rdy;
    logic       taken;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};
    assign mem_rdy      = MEM_HANDSHAKE ? mem_ready : 1'b1;

    alu_decode u_alu_decode (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal)
    );

    // funct3[2:1] picks the flag, funct3[0] inverts it
    always_comb begin
        case (funct3[2:1])
            2'b00:   taken = zero;
            2'b10:   taken = lt;
            2'b11:   taken = ltu;
            default: taken = 1'b0;
        endcase
        taken = taken ^ funct3[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXECR;
                        OP_IALU:           state_d = S_EXECI;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JUMP;
                        OP_JALR:           state_d = S_JALRADR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JUMP, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_JALRADR:  state_d = S_JUMP;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MDR;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = dec_alu;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dec_alu;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = ALU_SUB;
                pc_write  = taken;
            end
            S_JALRADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
            end
            S_LUI: begin
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                alu_ctrl  = ALU_PASSB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
        // no write or memory strobe may escape while reset is held
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: a per-instruction reference model queues the
// expected output vector of every cycle; a monitor compares them at negedge.
module tb_mc_cu;

    typedef struct packed {
        logic       pcw, irw, rw, mrd, mwr, adr;
        logic [1:0] a, b, rs;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } outs_t;

    typedef struct {
        outs_t e;
        outs_t m;
        bit    w;
        string tag;
    } sb_t;

    localparam outs_t FULL = '1;
    localparam outs_t STRB = '{pcw: 1'b1, irw: 1'b1, rw: 1'b1, mrd: 1'b1, mwr: 1'b1,
                               adr: 1'b0, a: 2'b0, b: 2'b0, rs: 2'b0, imm: 3'b0,
                               alu: 4'b0, ill: 1'b1};

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n;
    logic [31:0] instr1, instr2;
    logic        zero, lt, ltu, mr1, mr2;

    logic        p1_pcw, p1_irw, p1_rw, p1_mrd, p1_mwr, p1_adr, p1_ill;
    logic [1:0]  p1_a, p1_b, p1_rs;
    logic [2:0]  p1_imm;
    logic [3:0]  p1_alu;
    logic        p2_pcw, p2_irw, p2_rw, p2_mrd, p2_mwr, p2_adr, p2_ill;
    logic [1:0]  p2_a, p2_b, p2_rs;
    logic [2:0]  p2_imm;
    logic [3:0]  p2_alu;
    outs_t       act1, act2;

    logic [31:0] nx_instr;
    logic        nx_z, nx_lt, nx_ltu;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    mc_cu #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .instr(instr1), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mr1), .pc_write(p1_pcw), .ir_write(p1_irw), .reg_write(p1_rw),
        .mem_read(p1_mrd), .mem_write(p1_mwr), .adr_src(p1_adr), .alu_src_a(p1_a),
        .alu_src_b(p1_b), .result_src(p1_rs), .imm_src(p1_imm), .alu_ctrl(p1_alu),
        .illegal(p1_ill)
    );

    mc_cu #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst2_n), .instr(instr2), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mr2), .pc_write(p2_pcw), .ir_write(p2_irw), .reg_write(p2_rw),
        .mem_read(p2_mrd), .mem_write(p2_mwr), .adr_src(p2_adr), .alu_src_a(p2_a),
        .alu_src_b(p2_b), .result_src(p2_rs), .imm_src(p2_imm), .alu_ctrl(p2_alu),
        .illegal(p2_ill)
    );

    assign act1 = {p1_pcw, p1_irw, p1_rw, p1_mrd, p1_mwr, p1_adr, p1_a, p1_b, p1_rs,
                   p1_imm, p1_alu, p1_ill};
    assign act2 = {p2_pcw, p2_irw, p2_rw, p2_mrd, p2_mwr, p2_adr, p2_a, p2_b, p2_rs,
                   p2_imm, p2_alu, p2_ill};

    // monitor
    sb_t   cur;
    outs_t got;
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                cur = sbq.pop_front();
                got = cur.w ? act2 : act1;
                n_tests++;
                if (((got ^ cur.e) & cur.m) != '0) begin
                    n_fail++;
                    $display("FAIL %s dut%0d @%0t: got %05h, expected %05h (mask %05h)",
                             cur.tag, int'(cur.w) + 1, $time, got & cur.m, cur.e & cur.m, cur.m);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1, "watchdog");
    end

    function automatic outs_t sel(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] rs, input logic [2:0] imm,
                                  input logic [3:0] alu);
        outs_t o = '0;
        o.a = a; o.b = b; o.rs = rs; o.imm = imm; o.alu = alu;
        return o;
    endfunction

    function automatic outs_t fetch_o(input logic rdy);
        outs_t o = sel(2'b00, 2'b10, 2'b10, 3'd0, 4'd0);
        o.mrd = 1'b1; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    task automatic step(input bit w, input logic mr, input outs_t e, input outs_t m,
                        input string tag);
        @(posedge clk);
        #1;
        if (w) begin rst2_n = 1'b1; instr2 = nx_instr; mr2 = mr; end
        else   begin rst1_n = 1'b1; instr1 = nx_instr; mr1 = mr; end
        zero = nx_z; lt = nx_lt; ltu = nx_ltu;
        sbq.push_back('{e: e, m: m, w: w, tag: tag});
    endtask

    task automatic rst_step(input bit w);
        @(posedge clk);
        #1;
        if (w) rst2_n = 1'b0; else rst1_n = 1'b0;
        sbq.push_back('{e: '0, m: STRB, w: w, tag: "RESET"});
    endtask

    // dut1 waits on mem_ready and traps; dut2 ignores mem_ready (driven 0) and retires illegal as NOP
    task automatic run_instr(input bit w, input logic [31:0] ins, input int wf, input int wm,
                             input bit rst_in_store);
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        logic [3:0] base[8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        logic [3:0] op = base[f3];
        logic       rdy = w ? 1'b0 : 1'b1;
        logic       flag;
        bit         hs = !w;
        bit         bad = 0;
        outs_t      e;
        outs_t      wb = '0;
        outs_t      jmp = sel(2'b01, 2'b10, 2'b00, 3'd0, 4'd0);
        wb.rw = 1'b1;
        jmp.pcw = 1'b1;
        nx_instr = ins;
        case (opc)
            7'h33: begin
                if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) op = 4'd9;
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: if (f3 == 3'd5 && f7[5]) op = 4'd9;
            7'h63: bad = (f3 == 3'd2 || f3 == 3'd3);
            7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17: ;
            default: bad = 1;
        endcase

        if (hs) repeat (wf) step(w, 1'b0, fetch_o(1'b0), FULL, "FETCH-wait");
        step(w, rdy, fetch_o(1'b1), FULL, "FETCH");
        step(w, w ? 1'b0 : 1'($urandom), sel(2'b01, 2'b01, 2'b00,
             (opc == 7'h6F) ? 3'd3 : 3'd2, 4'd0), FULL, "DECODE");
        if (bad) begin
            if (hs) begin
                e = '0; e.ill = 1'b1;
                repeat (3) step(w, 1'($urandom), e, FULL, "TRAP");
                repeat (2) rst_step(w);
            end
            return;
        end
        case (opc)
            7'h03: begin
                step(w, 1'b0, sel(2'b10, 2'b01, 2'b00, 3'd0, 4'd0), FULL, "MEMADR");
                e = '0; e.mrd = 1'b1; e.adr = 1'b1;
                if (hs) repeat (wm) step(w, 1'b0, e, FULL, "MEMREAD-wait");
                step(w, rdy, e, FULL, "MEMREAD");
                e = sel(2'b00, 2'b00, 2'b01, 3'd0, 4'd0); e.rw = 1'b1;
                step(w, 1'b0, e, FULL, "MEMWB");
            end
            7'h23: begin
                step(w, 1'b0, sel(2'b10, 2'b01, 2'b00, 3'd1, 4'd0), FULL, "MEMADR");
                e = '0; e.mwr = 1'b1; e.adr = 1'b1;
                if (hs && rst_in_store) begin
                    step(w, 1'b0, e, FULL, "MEMWRITE-wait");
                    rst_step(w);
                    return;
                end
                if (hs) repeat (wm) step(w, 1'b0, e, FULL, "MEMWRITE-wait");
                step(w, rdy, e, FULL, "MEMWRITE");
            end
            7'h33: begin
                step(w, 1'b0, sel(2'b10, 2'b00, 2'b00, 3'd0, op), FULL, "EXECR");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
            7'h13: begin
                step(w, 1'b0, sel(2'b10, 2'b01, 2'b00, 3'd0, op), FULL, "EXECI");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
            7'h63: begin
                case (f3[2:1])
                    2'b00:   flag = nx_z;
                    2'b10:   flag = nx_lt;
                    default: flag = nx_ltu;
                endcase
                e = sel(2'b10, 2'b00, 2'b00, 3'd0, 4'd1);
                e.pcw = f3[0] ? !flag : flag;
                step(w, 1'b0, e, FULL, "BRANCH");
            end
            7'h6F: begin
                step(w, 1'b0, jmp, FULL, "JUMP");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
            7'h67: begin
                step(w, 1'b0, sel(2'b10, 2'b01, 2'b00, 3'd0, 4'd0), FULL, "JALRADR");
                step(w, 1'b0, jmp, FULL, "JUMP");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
            7'h37: begin
                step(w, 1'b0, sel(2'b00, 2'b01, 2'b00, 3'd4, 4'd10), FULL, "LUI");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
            default: begin
                step(w, 1'b0, sel(2'b01, 2'b01, 2'b00, 3'd4, 4'd0), FULL, "AUIPC");
                step(w, 1'b0, wb, FULL, "ALUWB");
            end
        endcase
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 9);
        case (k)
            0: begin
                r[6:0] = 7'h33;
                if ($urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            1: begin
                r[6:0] = 7'h13;
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
                if (r[14:12] == 3'd5) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6F;
            6: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            default: ;
        endcase
        return r;
    endfunction

    task automatic set_flags(input logic z, input logic l, input logic lu);
        nx_z = z; nx_lt = l; nx_ltu = lu;
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        instr1 = '0; instr2 = '0; mr1 = 1'b0; mr2 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        nx_instr = '0;
        set_flags(1'b0, 1'b0, 1'b0);
        rst_step(1'b0);
        rst_step(1'b0);

        run_instr(1'b0, 32'h002081B3, 0, 0, 1'b0);          // add x3,x1,x2
        run_instr(1'b0, 32'h0080A283, 0, 3, 1'b0);          // lw x5,8(x1), 3 wait cycles
        set_flags(1'b0, 1'b1, 1'b0);
        run_instr(1'b0, 32'h0020C063, 0, 0, 1'b0);          // blt, taken
        set_flags(1'b0, 1'b0, 1'b1);
        run_instr(1'b0, 32'h0020F063, 0, 0, 1'b0);          // bgeu, not taken
        run_instr(1'b0, 32'h000100E7, 2, 0, 1'b0);          // jalr x1,0(x2)
        run_instr(1'b0, 32'h0000007F, 0, 0, 1'b0);          // illegal opcode
        run_instr(1'b0, 32'h0020A023, 0, 2, 1'b1);          // sw, reset during MEMWRITE
        run_instr(1'b0, 32'h00000013, 1, 0, 1'b0);          // nop after reset

        for (int i = 0; i < 150; i++) begin
            set_flags(1'($urandom), 1'($urandom), 1'($urandom));
            run_instr(1'b0, gen(), $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 7) == 0);
        end

        rst_step(1'b0);
        rst_step(1'b1);
        run_instr(1'b1, 32'h0000007F, 0, 0, 1'b0);
        run_instr(1'b1, 32'h002081B3, 0, 0, 1'b0);
        run_instr(1'b1, 32'h0080A283, 2, 3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            set_flags(1'($urandom), 1'($urandom), 1'($urandom));
            run_instr(1'b1, gen(), 0, 0, 1'b0);
        end

        repeat (2) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle control unit for the RV32I core: a state machine that sequences each instruction over several clock cycles through one shared ALU and one unified memory port. It sits beside the datapath, reads the latched instruction and the ALU comparison flags, and drives every datapath mux, register-enable and memory strobe. Compared with the single-cycle decoder, it adds:
- the full branch set (beq/bne/blt/bge/bltu/bgeu);
- jal, jalr, lui and auipc;
- a variable-latency memory handshake;
- an illegal-instruction trap.

## Interface
- MEM_HANDSHAKE, 1, 1: wait on mem_ready; 0: treat mem_ready as always 1.
- TRAP_ON_ILLEGAL, 1, 1: an illegal instruction enters TRAP; 0: it is retired as a NOP.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents, stable after ir_write.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the access this cycle.
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  write enables and memory strobes.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 register.
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- result_src  out  2  result select: 00 = ALUOut, 01 = memory data register, 10 = ALU result.
- imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- alu_ctrl  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- illegal  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JUMP, JALRADR, LUI, AUIPC, TRAP.
- Any output not listed for a state is 0: strobes 0, selects 00, alu_ctrl = add.
- FETCH:
  - mem_read=1, adr_src=0; the ALU computes PC+4 (a=00, b=10, add, result_src=10).
  - ir_write and pc_write equal mem_ready. Leave FETCH only when mem_ready=1.
- DECODE:
  - ALUOut <- oldPC+imm, with a=01, b=01, add.
  - imm_src is J for jal and B otherwise.
  - Next state by opcode:
    - load or store -> MEMADR
    - R-type -> EXECR
    - I-ALU -> EXECI
    - branch -> BRANCH
    - jal -> JUMP
    - jalr -> JALRADR
    - lui -> LUI
    - auipc -> AUIPC
    - anything else -> TRAP, or FETCH when TRAP_ON_ILLEGAL=0.
- MEMADR: a=10, b=01, add; imm_src is I for loads and S for stores. Next state MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_read=1, adr_src=1; hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, result_src=01; next FETCH.
- MEMWRITE: mem_write=1, adr_src=1; hold until mem_ready=1, then FETCH.
- EXECR: a=10, b=00; alu_ctrl from funct3/funct7. Next ALUWB.
- EXECI: a=10, b=01, imm_src=I; alu_ctrl from funct3, using funct7[5] only for srai. Next ALUWB.
- ALUWB: reg_write=1, result_src=00; next FETCH.
- BRANCH:
  - a=10, b=00, sub, result_src=00.
  - pc_write = taken, decided by funct3:
    - 000 -> zero
    - 001 -> !zero
    - 100 -> lt
    - 101 -> !lt
    - 110 -> ltu
    - 111 -> !ltu
  - funct3 010 or 011 is illegal. Next FETCH.
- JALRADR: a=10, b=01, imm_src=I, add; ALUOut <- rs1+imm. Next JUMP.
- JUMP: pc_write=1, result_src=00 (target from ALUOut); a=01, b=10, add computes the link value. Next ALUWB.
- LUI: b=01, imm_src=U, passB; next ALUWB.
- AUIPC: a=01, b=01, imm_src=U, add; next ALUWB.
- TRAP: illegal=1 and all strobes 0. The FSM stays in TRAP until reset.
- Illegal encodings:
  - an unknown opcode;
  - a bad branch funct3;
  - funct7 not 0000000/0100000 on R-type;
  - funct7[5] set on R-type other than add/sub/srl/sra.

## Timing
- State updates on the rising edge of clk. All outputs are decoded combinationally from state, instr, flags and mem_ready.
- Cycle counts at zero wait: R-type, I-ALU, lui, auipc, jal and store take 4 cycles; load and jalr take 5; branch takes 3.
- Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes are held constant while waiting.
- While rst_n is low:
  - state = FETCH and illegal = 0;
  - pc_write, ir_write, reg_write and mem_write are forced to 0;
  - mem_read = 0.
- Release is synchronous to the next clock edge.
- Reset asserted mid-instruction aborts it immediately. No partial register write or memory write occurs after assertion.
- Branch flags are sampled in the same cycle they are produced. No flag registers.

## Structure
- cu_pkg holds:
  - the state enum;
  - opcode constants;
  - the alu_src_a, alu_src_b, result_src, imm_src and alu_ctrl encodings.
- One sub-module, alu_decode: maps opcode, funct3 and funct7 to alu_ctrl plus an illegal flag. It is purely combinational.
- The FSM (state register, next-state logic, output decode) lives in mc_cu.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1: FETCH->DECODE->EXECR->ALUWB. alu_ctrl=0000 in EXECR; reg_write=1 in cycle 4 only.
- lw x5,8(x1) with mem_ready low for 3 cycles in MEMREAD: 8 cycles total. mem_read and adr_src=1 held steady; reg_write=1 with result_src=01 in the final cycle.
- blt with lt=1 -> pc_write=1 in BRANCH. bgeu with ltu=1 -> pc_write=0. Both take 3 cycles.
- jalr x1,0(x2): states JALRADR then JUMP. pc_write=1 with result_src=00 in JUMP; ALUWB reg_write=1 follows.
- instr=0x0000007F (illegal opcode): with TRAP_ON_ILLEGAL=1, illegal=1 stays set forever and no strobes occur. With TRAP_ON_ILLEGAL=0, the FSM returns to FETCH after DECODE.
- rst_n pulsed low during MEMWRITE: mem_write drops in the same cycle; after release the FSM enters FETCH and illegal=0.
